// File: rtl/processing_unit_ctx.sv
// Union-find decoder processing element for one Z-type ancilla. It loads a
// syndrome bit, requests growth, merges roots with grown neighbours, tracks
// cluster parity, and drives peeling corrections per global stage. A
// request/acknowledge engine swaps the live PE state with a per-PE context RAM.
//
// Context handshake: ctx_switch_req is a level sampled only while the engine
// is idle. An in-range ctx_next is accepted, and ctx_switch_ack pulses for one
// cycle exactly three cycles later, together with the restored state. An
// out-of-range ctx_next pulses ctx_error instead and changes nothing. The
// controller drops req on ack; a req still high then starts another switch.
module processing_unit_ctx #(
  parameter int ADDRESS_WIDTH  = 6,
  parameter int NEIGHBOR_COUNT = 6,
  parameter int NUM_CONTEXTS   = 4,
  parameter int STAGE_WIDTH    = 3,
  localparam int CTX_W  = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
  localparam int LINK_W = ADDRESS_WIDTH + 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             measurement,
  output logic                             measurement_out,
  input  logic [STAGE_WIDTH-1:0]           global_stage,
  input  logic [NEIGHBOR_COUNT-1:0]        neighbor_fully_grown,
  input  logic [NEIGHBOR_COUNT-1:0]        neighbor_is_boundary,
  output logic                             neighbor_increase,
  output logic [NEIGHBOR_COUNT-1:0]        neighbor_is_error,
  input  logic [ADDRESS_WIDTH-1:0]         input_address,
  input  logic [NEIGHBOR_COUNT*LINK_W-1:0] input_data,
  output logic [NEIGHBOR_COUNT*LINK_W-1:0] output_data,
  output logic [ADDRESS_WIDTH-1:0]         root,
  output logic                             odd,
  output logic                             busy,
  input  logic                             ctx_switch_req,
  input  logic [CTX_W-1:0]                 ctx_next,
  output logic                             ctx_switch_ack,
  output logic                             ctx_error,
  output logic [CTX_W-1:0]                 ctx_current,
  output logic [1:0]                       ctx_state
);

  // Global stage codes shared with the stage controller.
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE          = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT   = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW          = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE         = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING       = STAGE_WIDTH'(4);
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID  = STAGE_WIDTH'(5);
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESET_ROOTS   = STAGE_WIDTH'(6);

  localparam int WORD_W = NEIGHBOR_COUNT + ADDRESS_WIDTH + 3;

  typedef enum logic [1:0] {CX_IDLE, CX_SAVE, CX_READ, CX_LOAD} cx_state_t;

  cx_state_t                  cx_state;
  logic [STAGE_WIDTH-1:0]     stage;
  logic [STAGE_WIDTH-1:0]     last_stage;
  logic                       m;
  logic                       cluster_parity;
  logic                       busy_r;
  logic [NEIGHBOR_COUNT-1:0]  parent_vector;
  logic [CTX_W-1:0]           ctx_target;

  logic [WORD_W-1:0]          ctx_ram [NUM_CONTEXTS];
  logic [WORD_W-1:0]          ram_dout;
  logic [WORD_W-1:0]          live_word;

  logic [ADDRESS_WIDTH-1:0]   link_root [NEIGHBOR_COUNT];
  logic [NEIGHBOR_COUNT-1:0]  link_parent;
  logic [NEIGHBOR_COUNT-1:0]  link_odd;
  logic [NEIGHBOR_COUNT-1:0]  link_parity;

  logic [NEIGHBOR_COUNT-1:0]  valid_links;
  logic                       any_boundary;
  logic                       cand_found;
  logic [ADDRESS_WIDTH-1:0]   cand_root;
  logic [NEIGHBOR_COUNT-1:0]  tie_mask;
  logic                       next_parity;
  logic [ADDRESS_WIDTH-1:0]   root_modified;
  logic [ADDRESS_WIDTH-1:0]   merge_root;
  logic [NEIGHBOR_COUNT-1:0]  merge_parent;
  logic                       merge_odd;
  logic                       merge_changed;
  logic [NEIGHBOR_COUNT-1:0]  border;

  // Unpack neighbour fields and pack our own view back out per link.
  for (genvar i = 0; i < NEIGHBOR_COUNT; i++) begin : g_link
    assign link_root[i]   = input_data[i*LINK_W +: ADDRESS_WIDTH];
    assign link_parent[i] = input_data[i*LINK_W + ADDRESS_WIDTH];
    assign link_odd[i]    = input_data[i*LINK_W + ADDRESS_WIDTH + 1];
    assign link_parity[i] = input_data[i*LINK_W + ADDRESS_WIDTH + 2];
    assign output_data[i*LINK_W +: LINK_W] =
      {cluster_parity, odd, parent_vector[i], root};
  end

  assign measurement_out = m;
  assign busy            = busy_r | (cx_state != CX_IDLE);
  assign ctx_state       = cx_state;
  assign live_word       = {cluster_parity, parent_vector, root, odd, m};

  // Merge decision: minimum grown root, boundary-adjusted own root, parity.
  always_comb begin
    valid_links  = neighbor_fully_grown & ~neighbor_is_boundary;
    any_boundary = |neighbor_is_boundary;
    cand_found   = 1'b0;
    cand_root    = '1;
    tie_mask     = '0;
    next_parity  = m;
    border       = '0;
    for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
      if (valid_links[i] && (!cand_found || link_root[i] < cand_root)) begin
        cand_root  = link_root[i];
        cand_found = 1'b1;
      end
      next_parity = next_parity ^ (link_parent[i] & link_parity[i]);
    end
    for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
      tie_mask[i] = valid_links[i] && (link_root[i] == cand_root);
    end
    root_modified = any_boundary ? {1'b0, input_address[ADDRESS_WIDTH-2:0]} : root;
    merge_root    = root;
    merge_parent  = parent_vector;
    if (cand_found && cand_root < root_modified && cand_root < root) begin
      merge_root   = cand_root;
      merge_parent = tie_mask;
    end else if (root_modified < root) begin
      merge_root   = root_modified;
      merge_parent = '0;
    end
    merge_odd = (parent_vector != '0) ? |(parent_vector & link_odd)
                                      : (next_parity & ~any_boundary);
    merge_changed = (merge_root != root) || (next_parity != cluster_parity) ||
                    (merge_odd != odd);
    // Later (higher-index) boundary links overwrite earlier ones.
    if (parent_vector == '0 && next_parity) begin
      for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
        if (neighbor_is_boundary[i]) begin
          border    = '0;
          border[i] = 1'b1;
        end
      end
    end
  end

  // Stage-keyed combinational outputs: growth request and peeling corrections.
  always_comb begin
    neighbor_increase = (stage == STAGE_GROW) && (last_stage != STAGE_GROW) && odd;
    neighbor_is_error = '0;
    if (stage == STAGE_PEELING) begin
      neighbor_is_error = (cluster_parity ? parent_vector : '0) | border;
    end
  end

  // Context RAM: write in SAVE, registered read in READ; contents never reset.
  always_ff @(posedge clk) begin
    if (!reset && cx_state == CX_SAVE) begin
      ctx_ram[ctx_current] <= live_word;
    end
    if (cx_state == CX_READ) begin
      ram_dout <= ctx_ram[ctx_target];
    end
  end

  // PE state, stage pipeline and context-switch FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage          <= STAGE_IDLE;
      last_stage     <= STAGE_IDLE;
      m              <= 1'b0;
      odd            <= 1'b0;
      cluster_parity <= 1'b0;
      busy_r         <= 1'b0;
      root           <= input_address;
      parent_vector  <= '0;
      ctx_current    <= '0;
      ctx_target     <= '0;
      cx_state       <= CX_IDLE;
      ctx_switch_ack <= 1'b0;
      ctx_error      <= 1'b0;
    end else begin
      stage          <= global_stage;
      last_stage     <= stage;
      ctx_switch_ack <= 1'b0;
      ctx_error      <= 1'b0;
      case (cx_state)
        CX_IDLE: begin
          if (ctx_switch_req) begin
            if (int'(ctx_next) >= NUM_CONTEXTS) begin
              ctx_error <= 1'b1;
            end else begin
              ctx_target <= ctx_next;
              cx_state   <= CX_SAVE;
            end
          end
        end
        CX_SAVE: cx_state <= CX_READ;
        CX_READ: cx_state <= CX_LOAD;
        CX_LOAD: begin
          {cluster_parity, parent_vector, root, odd, m} <= ram_dout;
          ctx_current    <= ctx_target;
          ctx_switch_ack <= 1'b1;
          cx_state       <= CX_IDLE;
        end
        default: cx_state <= CX_IDLE;
      endcase
      if (cx_state == CX_IDLE) begin
        case (stage)
          STAGE_MEASUREMENT: begin
            m              <= measurement;
            odd            <= measurement;
            cluster_parity <= measurement;
            root           <= input_address;
            parent_vector  <= '0;
          end
          STAGE_RESULT_VALID: m <= measurement;
          STAGE_RESET_ROOTS: begin
            root          <= input_address;
            parent_vector <= '0;
          end
          STAGE_MERGE: begin
            root           <= merge_root;
            parent_vector  <= merge_parent;
            cluster_parity <= next_parity;
            odd            <= merge_odd;
            busy_r         <= merge_changed;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_processing_unit_ctx.sv
// Bench for processing_unit_ctx: directed scenarios followed by randomized
// stage and context-switch traffic, all compared against a behavioural model.
module tb_processing_unit_ctx;

  localparam int AW   = 6;
  localparam int NC   = 6;
  localparam int NCTX = 3;
  localparam int SW   = 3;
  localparam int CW   = 2;
  localparam int LW   = AW + 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_GROW   = 3'd2;
  localparam logic [2:0] ST_MERGE  = 3'd3;
  localparam logic [2:0] ST_PEEL   = 3'd4;
  localparam logic [2:0] ST_RESULT = 3'd5;
  localparam logic [2:0] ST_RROOTS = 3'd6;

  logic              clk;
  logic              reset;
  logic              measurement;
  logic              measurement_out;
  logic [SW-1:0]     global_stage;
  logic [NC-1:0]     neighbor_fully_grown;
  logic [NC-1:0]     neighbor_is_boundary;
  logic              neighbor_increase;
  logic [NC-1:0]     neighbor_is_error;
  logic [AW-1:0]     input_address;
  logic [NC*LW-1:0]  input_data;
  logic [NC*LW-1:0]  output_data;
  logic [AW-1:0]     root;
  logic              odd;
  logic              busy;
  logic              ctx_switch_req;
  logic [CW-1:0]     ctx_next;
  logic              ctx_switch_ack;
  logic              ctx_error;
  logic [CW-1:0]     ctx_current;
  logic [1:0]        ctx_state;

  processing_unit_ctx #(
    .ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(NC), .NUM_CONTEXTS(NCTX), .STAGE_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .measurement(measurement),
    .measurement_out(measurement_out), .global_stage(global_stage),
    .neighbor_fully_grown(neighbor_fully_grown),
    .neighbor_is_boundary(neighbor_is_boundary),
    .neighbor_increase(neighbor_increase), .neighbor_is_error(neighbor_is_error),
    .input_address(input_address), .input_data(input_data),
    .output_data(output_data), .root(root), .odd(odd), .busy(busy),
    .ctx_switch_req(ctx_switch_req), .ctx_next(ctx_next),
    .ctx_switch_ack(ctx_switch_ack), .ctx_error(ctx_error),
    .ctx_current(ctx_current), .ctx_state(ctx_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic          cp;
    logic [NC-1:0] pv;
    logic [AW-1:0] root;
    logic          odd;
    logic          m;
    bit            known;
  } ctx_t;

  ctx_t          mem [NCTX];
  logic [2:0]    m_stage, m_last;
  logic          m_m, m_odd, m_cp, m_busy, m_ack, m_err;
  logic [AW-1:0] m_root;
  logic [NC-1:0] m_pv;
  logic [CW-1:0] m_ctx, m_tgt;
  int            m_left;   // cycles still to go in a switch, 0 when idle
  bit            m_known;  // live state is defined (not a never-saved restore)

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic link_bit(input int i, input int off);
    return input_data[i*LW + off];
  endfunction

  function automatic logic model_parity();
    logic p;
    p = m_m;
    for (int i = 0; i < NC; i++) p = p ^ (link_bit(i, AW) & link_bit(i, AW + 2));
    return p;
  endfunction

  function automatic logic [NC-1:0] exp_peel();
    logic [NC-1:0] b;
    b = '0;
    if (m_stage != ST_PEEL) return '0;
    if (m_pv == '0 && model_parity()) begin
      for (int i = NC - 1; i >= 0; i--) begin
        if (neighbor_is_boundary[i]) begin
          b[i] = 1'b1;
          break;
        end
      end
    end
    return (m_cp ? m_pv : '0) | b;
  endfunction

  function automatic logic [NC*LW-1:0] exp_out();
    logic [NC*LW-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i*LW +: LW] = {m_cp, m_odd, m_pv[i], m_root};
    return v;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    logic          np, anyb, new_odd;
    int            best, r;
    logic [NC-1:0] mask, new_pv, odd_bits;
    logic [AW-1:0] rmod, new_root;
    logic [2:0]    old_stage;
    if (reset) begin
      m_stage = ST_IDLE; m_last = ST_IDLE; m_m = 0; m_odd = 0; m_cp = 0;
      m_busy = 0; m_root = input_address; m_pv = '0; m_ctx = '0; m_left = 0;
      m_ack = 0; m_err = 0; m_known = 1;
      return;
    end
    np = model_parity();
    anyb = |neighbor_is_boundary;
    best = -1;
    mask = '0;
    for (int i = 0; i < NC; i++) begin
      odd_bits[i] = link_bit(i, AW + 1);
      if (neighbor_fully_grown[i] && !neighbor_is_boundary[i]) begin
        r = int'(input_data[i*LW +: AW]);
        if (best < 0 || r < best) best = r;
      end
    end
    for (int i = 0; i < NC; i++)
      mask[i] = neighbor_fully_grown[i] && !neighbor_is_boundary[i] &&
                (int'(input_data[i*LW +: AW]) == best);
    rmod = anyb ? {1'b0, input_address[AW-2:0]} : m_root;
    new_root = m_root;
    new_pv = m_pv;
    if (best >= 0 && best < int'(rmod) && best < int'(m_root)) begin
      new_root = AW'(best);
      new_pv = mask;
    end else if (rmod < m_root) begin
      new_root = rmod;
      new_pv = '0;
    end
    new_odd = (m_pv != '0) ? |(m_pv & odd_bits) : (np & ~anyb);
    old_stage = m_stage;
    m_last = m_stage;
    m_stage = global_stage;
    m_ack = 0;
    m_err = 0;
    if (m_left == 0) begin
      case (old_stage)
        ST_LOAD: begin
          m_m = measurement; m_odd = measurement; m_cp = measurement;
          m_root = input_address; m_pv = '0; m_known = 1;
        end
        ST_RESULT: m_m = measurement;
        ST_RROOTS: begin m_root = input_address; m_pv = '0; end
        ST_MERGE: begin
          m_busy = (new_root != m_root) || (np != m_cp) || (new_odd != m_odd);
          m_root = new_root; m_pv = new_pv; m_cp = np; m_odd = new_odd;
        end
        default: ;
      endcase
      if (ctx_switch_req) begin
        if (int'(ctx_next) >= NCTX) m_err = 1;
        else begin m_tgt = ctx_next; m_left = 3; end
      end
    end else if (m_left == 3) begin
      mem[m_ctx].cp = m_cp; mem[m_ctx].pv = m_pv; mem[m_ctx].root = m_root;
      mem[m_ctx].odd = m_odd; mem[m_ctx].m = m_m; mem[m_ctx].known = m_known;
      m_left = 2;
    end else if (m_left == 2) begin
      m_left = 1;
    end else begin
      m_cp = mem[m_tgt].cp; m_pv = mem[m_tgt].pv; m_root = mem[m_tgt].root;
      m_odd = mem[m_tgt].odd; m_m = mem[m_tgt].m; m_known = mem[m_tgt].known;
      m_ctx = m_tgt; m_ack = 1; m_left = 0;
    end
  endtask

  task automatic check_outputs();
    check("ack", ctx_switch_ack, m_ack);
    check("ctx_error", ctx_error, m_err);
    check("ctx_current", ctx_current, m_ctx);
    check("fsm_idle", ctx_state == 2'd0, m_left == 0);
    check("busy", busy, m_busy | (m_left != 0));
    if (m_known) begin
      check("measurement_out", measurement_out, m_m);
      check("root", root, m_root);
      check("odd", odd, m_odd);
      check("increase", neighbor_increase,
            (m_stage == ST_GROW) && (m_last != ST_GROW) && m_odd);
      check("is_error", neighbor_is_error, exp_peel());
      check("output_data", output_data, exp_out());
    end
  endtask

  // Driver tasks
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_link(input int i, input logic [AW-1:0] r, input logic par,
                          input logic od, input logic cp);
    input_data[i*LW +: LW] = {cp, od, par, r};
  endtask

  task automatic do_switch(input logic [CW-1:0] tgt);
    int n;
    global_stage = ST_IDLE;
    ctx_switch_req = 1'b1;
    ctx_next = tgt;
    tick();
    n = 0;
    while (!ctx_switch_ack && n < 8) begin
      tick();
      n++;
    end
    ctx_switch_req = 1'b0;
    check("ack_latency", n, 3);
  endtask

  task automatic do_load(input logic meas);
    measurement = meas;
    global_stage = ST_LOAD;
    tick();
    global_stage = ST_IDLE;
    tick();
  endtask

  logic [63:0] rnd;
  logic [31:0] r32;
  int          op;

  initial begin
    for (int i = 0; i < NCTX; i++) mem[i].known = 0;
    m_left = 0; m_known = 0; m_ctx = '0; m_tgt = '0;
    reset = 1'b1; measurement = 1'b0; global_stage = ST_IDLE;
    neighbor_fully_grown = '0; neighbor_is_boundary = '0;
    input_address = 6'b100101; input_data = '0;
    ctx_switch_req = 1'b0; ctx_next = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_root", root, 6'd37);
    check("reset_ctx", ctx_current, 0);
    check("reset_busy", busy, 0);

    // Load and growth request
    do_load(1'b1);
    check("load_odd", odd, 1);
    check("load_root", root, 6'd37);
    global_stage = ST_GROW;
    tick();
    check("grow_first", neighbor_increase, 1);
    tick();
    check("grow_second", neighbor_increase, 0);

    // Merge toward a smaller grown root
    set_link(2, 6'd33, 1'b0, 1'b1, 1'b0);
    neighbor_fully_grown = 6'b000100;
    global_stage = ST_MERGE;
    tick();
    tick();
    check("merge_root", root, 6'd33);
    check("merge_parent", output_data[2*LW + AW], 1);
    check("merge_busy", busy, 1);
    tick();
    check("merge_settled", busy, 0);

    // Boundary merge and peeling border selection
    input_data = '0;
    neighbor_fully_grown = '0;
    do_load(1'b1);
    neighbor_fully_grown = 6'b010000;
    neighbor_is_boundary = 6'b010000;
    global_stage = ST_MERGE;
    tick();
    tick();
    check("boundary_root", root, 6'd5);
    check("boundary_odd", odd, 0);
    global_stage = ST_PEEL;
    neighbor_fully_grown = 6'b010010;
    neighbor_is_boundary = 6'b010010;
    tick();
    check("peel_border", neighbor_is_error, 6'b010000);
    neighbor_fully_grown = 6'b001001;
    neighbor_is_boundary = 6'b001001;
    tick();
    check("peel_priority", neighbor_is_error, 6'b001000);
    neighbor_fully_grown = '0;
    neighbor_is_boundary = '0;

    // Context round trips: S0 in ctx0, S2 in ctx2, wrap 2 -> 0
    do_switch(2'd2);
    input_address = 6'b110000;
    do_load(1'b0);
    do_switch(2'd0);
    check("restore_s0", root, 6'd5);
    do_switch(2'd2);
    check("restore_s2", root, 6'd48);
    do_switch(2'd2);
    check("same_ctx", root, 6'd48);

    // Out-of-range request is rejected
    ctx_switch_req = 1'b1;
    ctx_next = 2'd3;
    tick();
    check("bad_ctx_pulse", ctx_error, 1);
    ctx_switch_req = 1'b0;
    tick();
    check("bad_ctx_state", root, 6'd48);

    // Reset while reading the target context
    ctx_switch_req = 1'b1;
    ctx_next = 2'd1;
    tick();
    ctx_switch_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_ctx", ctx_current, 0);
    check("midreset_idle", ctx_state, 0);
    repeat (4) tick();

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 11);
      if (op == 0) begin
        do_switch(CW'($urandom_range(0, NCTX - 1)));
        if (!m_known) do_load(1'($urandom_range(0, 1)));
      end else if (op == 1) begin
        ctx_switch_req = 1'b1;
        ctx_next = 2'd3;
        tick();
        ctx_switch_req = 1'b0;
      end else begin
        rnd = {$urandom(), $urandom()};
        r32 = $urandom();
        input_data = rnd[NC*LW-1:0];
        neighbor_fully_grown = r32[5:0];
        neighbor_is_boundary = r32[11:6] & r32[17:12] & r32[5:0];
        global_stage = r32[26:24];
        measurement = r32[27];
        if (r32[28]) input_address = {1'b1, rnd[58:54]};
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
